// File: rtl/user_io_arbiter.sv
// Wishbone-mapped controller for 16 user IO pins: register/LA pin arbitration,
// input synchronisation, rising-edge interrupts and an LA-ownership write error flag.
module user_io_arbiter #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int unsigned NPIN        = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic [NPIN-1:0]   io_in,
  output logic [NPIN-1:0]   io_out,
  output logic [NPIN-1:0]   io_oeb,
  input  logic [3*NPIN-1:0] la_data_in,
  input  logic [3*NPIN-1:0] la_oenb,
  output logic [2*NPIN-1:0] la_data_out,
  output logic [2:0]        irq
);

  typedef enum logic {S_IDLE, S_ACK} state_e;

  state_e state_q, state_d;

  logic [NPIN-1:0] out_q, out_d;
  logic [NPIN-1:0] oeb_q, oeb_d;
  logic [NPIN-1:0] own_q, own_d;
  logic [NPIN-1:0] en_q, en_d;
  logic [NPIN-1:0] stat_q, stat_d;
  logic            err_q, err_d;
  logic [31:0]     dat_q, dat_d;
  logic [2:0]      irq_q, irq_d;

  logic [SYNC_STAGES*NPIN-1:0] sync_q, sync_d;
  logic [NPIN-1:0] in_q;
  logic [NPIN-1:0] in_dly_q;
  logic [NPIN-1:0] rise;

  logic            hit, accept, wr, rd, mapped;
  logic [2:0]      reg_idx;
  logic [NPIN-1:0] lane_m, wdat, merged, stat_clr, owned;
  logic [NPIN-1:0] la_out, la_oe;
  logic            err_set, err_clr;
  logic [31:0]     rdata;
  logic            unused_ok;

  assign unused_ok = ^{wbs_sel_i[3:2], wbs_dat_i[31:NPIN]};

  // Bus decode
  assign hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign accept  = (state_q == S_IDLE) & hit;
  assign wr      = accept & wbs_we_i;
  assign rd      = accept & ~wbs_we_i;
  assign mapped  = (wbs_adr_i[1:0] == 2'b00) && (wbs_adr_i[7:2] <= 6'd6);
  assign reg_idx = wbs_adr_i[4:2];
  assign lane_m  = {{(NPIN/2){wbs_sel_i[1]}}, {(NPIN/2){wbs_sel_i[0]}}};
  assign wdat    = wbs_dat_i[NPIN-1:0];

  // Pin arbitration
  assign owned  = own_q & la_data_in[NPIN-1:0] & ~la_oenb[NPIN-1:0];
  assign la_out = la_data_in[2*NPIN-1:NPIN]   & ~la_oenb[2*NPIN-1:NPIN];
  assign la_oe  = la_data_in[3*NPIN-1:2*NPIN] & ~la_oenb[3*NPIN-1:2*NPIN];
  assign io_out = (owned & la_out) | (~owned & out_q);
  assign io_oeb = (owned & la_oe)  | (~owned & oeb_q);

  // Input synchroniser and edge detect
  assign sync_d = {sync_q[(SYNC_STAGES-1)*NPIN-1:0], io_in};
  assign in_q   = sync_q[SYNC_STAGES*NPIN-1 -: NPIN];
  assign rise   = in_q & ~in_dly_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (hit) state_d = S_ACK;
      S_ACK:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rdata = '0;
    if (mapped) begin
      case (reg_idx)
        3'd0: rdata[NPIN-1:0] = out_q;
        3'd1: rdata[NPIN-1:0] = oeb_q;
        3'd2: rdata[NPIN-1:0] = in_q;
        3'd3: rdata[NPIN-1:0] = own_q;
        3'd4: rdata[NPIN-1:0] = en_q;
        3'd5: rdata[NPIN-1:0] = stat_q;
        3'd6: rdata[0]        = err_q;
        default: rdata = '0;
      endcase
    end
  end

  always_comb begin
    merged   = (wdat & lane_m);
    out_d    = out_q;
    oeb_d    = oeb_q;
    own_d    = own_q;
    en_d     = en_q;
    stat_clr = '0;
    err_clr  = 1'b0;
    err_set  = 1'b0;
    if (wr && mapped) begin
      case (reg_idx)
        3'd0: begin
          out_d   = (out_q & ~lane_m) | merged;
          err_set = |(lane_m & owned);
        end
        3'd1: oeb_d = (oeb_q & ~lane_m) | merged;
        3'd3: own_d = (own_q & ~lane_m) | merged;
        3'd4: en_d  = (en_q  & ~lane_m) | merged;
        3'd5: stat_clr = merged;
        3'd6: err_clr  = merged[0];
        default: ;
      endcase
    end
    // New events take priority over a same-cycle W1C
    stat_d = (stat_q & ~stat_clr) | (rise & en_q);
    err_d  = (err_q & ~err_clr) | err_set;
    dat_d  = rd ? rdata : '0;
    irq_d  = {err_q, |stat_q[NPIN-1:NPIN/2], |stat_q[NPIN/2-1:0]};
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q  <= S_IDLE;
      out_q    <= '0;
      oeb_q    <= '1;
      own_q    <= '0;
      en_q     <= '0;
      stat_q   <= '0;
      err_q    <= 1'b0;
      dat_q    <= '0;
      irq_q    <= '0;
      sync_q   <= '0;
      in_dly_q <= '0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      oeb_q    <= oeb_d;
      own_q    <= own_d;
      en_q     <= en_d;
      stat_q   <= stat_d;
      err_q    <= err_d;
      dat_q    <= dat_d;
      irq_q    <= irq_d;
      sync_q   <= sync_d;
      in_dly_q <= in_q;
    end
  end

  assign wbs_ack_o   = (state_q == S_ACK);
  assign wbs_dat_o   = dat_q;
  assign irq         = irq_q;
  assign la_data_out = {stat_q, in_q};

endmodule

// File: tb/tb_user_io_arbiter.sv
// Directed self-checking bench for user_io_arbiter: registers, lanes, LA override,
// edge interrupts, W1C collisions, unmapped/undecoded access and reset behaviour.
module tb_user_io_arbiter;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] dat_o;
  logic [15:0] io_in, io_out, io_oeb;
  logic [47:0] la_in, la_oenb;
  logic [31:0] la_out;
  logic [2:0]  irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  user_io_arbiter #(.BASE_ADDR(BASE), .NPIN(16), .SYNC_STAGES(2)) dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb),
    .la_data_in(la_in), .la_oenb(la_oenb), .la_data_out(la_out), .irq(irq)
  );

  // Called at posedge+1; drives a request, waits up to 8 edges for ack.
  task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, output bit got, output int lat,
                         output logic [31:0] rdat, output logic ack_after);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    got = 1'b0; lat = 0; rdat = '0;
    for (int n = 1; n <= 8 && !got; n++) begin
      @(posedge clk); #1;
      if (ack) begin got = 1'b1; lat = n; rdat = dat_o; end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    ack_after = ack;
  endtask

  task automatic test_reset();
    bit g; int l; logic [31:0] r; logic aa;
    rst_n = 1'b0;
    #12;
    checks++; if (io_oeb !== 16'hFFFF) begin errors++; $display("FAIL rst_oeb got %h exp ffff", io_oeb); end
    checks++; if (io_out !== 16'h0000) begin errors++; $display("FAIL rst_out got %h exp 0000", io_out); end
    checks++; if (irq !== 3'b000) begin errors++; $display("FAIL rst_irq got %b exp 000", irq); end
    checks++; if (ack !== 1'b0 || dat_o !== 32'h0) begin errors++; $display("FAIL rst_ack got %b/%h exp 0/0", ack, dat_o); end
    checks++; if (la_out !== 32'h0) begin errors++; $display("FAIL rst_la got %h exp 0", la_out); end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    wb_xfer(BASE + 32'h04, 1'b0, 32'h0, 4'hF, g, l, r, aa);
    checks++; if (!g || r !== 32'h0000_FFFF) begin errors++; $display("FAIL rst_rd_oeb got %b/%h exp 1/0000ffff", g, r); end
  endtask

  task automatic test_write_lanes();
    bit g; int l; logic [31:0] r; logic aa;
    wb_xfer(BASE, 1'b1, 32'hFFFF_A5A5, 4'b0001, g, l, r, aa);
    checks++; if (!g || l != 1 || aa !== 1'b0) begin errors++; $display("FAIL wr_ack_timing got g=%b lat=%0d after=%b exp 1/1/0", g, l, aa); end
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL wr_dat_o got %h exp 0", r); end
    wb_xfer(BASE, 1'b0, 32'h0, 4'hF, g, l, r, aa);
    checks++; if (!g || r !== 32'h0000_00A5) begin errors++; $display("FAIL rd_out_lane0 got %h exp 000000a5", r); end
    checks++; if (io_out !== 16'h00A5) begin errors++; $display("FAIL io_out_lane0 got %h exp 00a5", io_out); end
    wb_xfer(BASE, 1'b1, 32'h0000_5A00, 4'b1110, g, l, r, aa);
    wb_xfer(BASE, 1'b0, 32'h0, 4'hF, g, l, r, aa);
    checks++; if (r !== 32'h0000_5AA5) begin errors++; $display("FAIL rd_out_lane1 got %h exp 00005aa5", r); end
  endtask

  task automatic test_unmapped();
    bit g; int l; logic [31:0] r; logic aa;
    wb_xfer(BASE + 32'h40, 1'b0, 32'h0, 4'hF, g, l, r, aa);
    checks++; if (!g || l != 1 || r !== 32'h0) begin errors++; $display("FAIL unmapped_40 got g=%b lat=%0d dat=%h exp 1/1/0", g, l, r); end
    wb_xfer(BASE + 32'h02, 1'b1, 32'h0000_1234, 4'b0011, g, l, r, aa);
    checks++; if (!g) begin errors++; $display("FAIL misaligned_ack got %b exp 1", g); end
    wb_xfer(BASE, 1'b0, 32'h0, 4'hF, g, l, r, aa);
    checks++; if (r !== 32'h0000_5AA5) begin errors++; $display("FAIL misaligned_ignored got %h exp 00005aa5", r); end
    wb_xfer(BASE + 32'h100, 1'b0, 32'h0, 4'hF, g, l, r, aa);
    checks++; if (g !== 1'b0) begin errors++; $display("FAIL undecoded_noack got %b exp 0", g); end
  endtask

  task automatic test_la_override();
    bit g; int l; logic [31:0] r; logic aa;
    wb_xfer(BASE, 1'b1, 32'h0, 4'b0011, g, l, r, aa);
    la_oenb = '1; la_oenb[0] = 1'b0; la_oenb[16] = 1'b0; la_oenb[32] = 1'b0;
    la_in = '0; la_in[0] = 1'b1; la_in[16] = 1'b1; la_in[32] = 1'b0;
    #1;
    checks++; if (io_out[0] !== 1'b0 || io_oeb[0] !== 1'b1) begin errors++; $display("FAIL la_not_owned got %b/%b exp 0/1", io_out[0], io_oeb[0]); end
    wb_xfer(BASE + 32'h0C, 1'b1, 32'h0001, 4'b0011, g, l, r, aa);
    checks++; if (io_out !== 16'h0001 || io_oeb !== 16'hFFFE) begin errors++; $display("FAIL la_owned got %h/%h exp 0001/fffe", io_out, io_oeb); end
    la_in[32] = 1'b1; la_oenb[32] = 1'b1; la_oenb[16] = 1'b1; #1;
    checks++; if (io_out[0] !== 1'b0 || io_oeb[0] !== 1'b0) begin errors++; $display("FAIL la_invalid_bits got %b/%b exp 0/0", io_out[0], io_oeb[0]); end
    la_oenb[32] = 1'b0; la_oenb[16] = 1'b0; la_in[32] = 1'b0; la_in[0] = 1'b0; #1;
    checks++; if (io_out[0] !== 1'b0 || io_oeb[0] !== 1'b1) begin errors++; $display("FAIL la_drop_req got %b/%b exp 0/1", io_out[0], io_oeb[0]); end
    la_in[0] = 1'b1; #1;
  endtask

  task automatic test_err();
    bit g; int l; logic [31:0] r; logic aa;
    wb_xfer(BASE, 1'b1, 32'h0001, 4'b0001, g, l, r, aa);
    checks++; if (irq !== 3'b100) begin errors++; $display("FAIL err_irq2 got %b exp 100", irq); end
    wb_xfer(BASE + 32'h18, 1'b0, 32'h0, 4'hF, g, l, r, aa);
    checks++; if (r !== 32'h1) begin errors++; $display("FAIL err_read got %h exp 1", r); end
    wb_xfer(BASE, 1'b0, 32'h0, 4'hF, g, l, r, aa);
    checks++; if (r !== 32'h1) begin errors++; $display("FAIL err_write_stored got %h exp 1", r); end
    wb_xfer(BASE + 32'h18, 1'b1, 32'h1, 4'b0001, g, l, r, aa);
    checks++; if (irq !== 3'b000) begin errors++; $display("FAIL err_w1c got %b exp 000", irq); end
    wb_xfer(BASE, 1'b1, 32'hFF00, 4'b0010, g, l, r, aa);
    wb_xfer(BASE + 32'h18, 1'b0, 32'h0, 4'hF, g, l, r, aa);
    checks++; if (r !== 32'h0 || irq[2] !== 1'b0) begin errors++; $display("FAIL err_other_lane got %h/%b exp 0/0", r, irq[2]); end
    wb_xfer(BASE + 32'h0C, 1'b1, 32'h0, 4'b0011, g, l, r, aa);
    la_in = '0; la_oenb = '1;
  endtask

  task automatic test_irq();
    bit g; int l; logic [31:0] r; logic aa;
    wb_xfer(BASE + 32'h10, 1'b1, 32'h0100, 4'b0010, g, l, r, aa);
    io_in[8] = 1'b1;
    repeat (3) @(posedge clk); #1;
    checks++; if (irq !== 3'b000) begin errors++; $display("FAIL irq_early got %b exp 000", irq); end
    @(posedge clk); #1;
    checks++; if (irq !== 3'b010) begin errors++; $display("FAIL irq_latency got %b exp 010", irq); end
    checks++; if (la_out !== 32'h0100_0100) begin errors++; $display("FAIL la_data_out got %h exp 01000100", la_out); end
    wb_xfer(BASE + 32'h08, 1'b0, 32'h0, 4'hF, g, l, r, aa);
    checks++; if (r !== 32'h0000_0100) begin errors++; $display("FAIL in_read got %h exp 00000100", r); end
    wb_xfer(BASE + 32'h14, 1'b1, 32'h0100, 4'b0010, g, l, r, aa);
    checks++; if (irq !== 3'b000) begin errors++; $display("FAIL irq_w1c got %b exp 000", irq); end
  endtask

  task automatic test_set_wins();
    bit g; int l; logic [31:0] r; logic aa;
    io_in[8] = 1'b0;
    repeat (4) @(posedge clk); #1;
    io_in[8] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    wb_xfer(BASE + 32'h14, 1'b1, 32'h0100, 4'b0010, g, l, r, aa);
    checks++; if (irq[1] !== 1'b1) begin errors++; $display("FAIL set_wins_irq got %b exp 1", irq[1]); end
    wb_xfer(BASE + 32'h10, 1'b1, 32'h0, 4'b0011, g, l, r, aa);
    wb_xfer(BASE + 32'h14, 1'b0, 32'h0, 4'hF, g, l, r, aa);
    checks++; if (r !== 32'h0000_0100 || irq[1] !== 1'b1) begin errors++; $display("FAIL en_off_keeps got %h/%b exp 00000100/1", r, irq[1]); end
    wb_xfer(BASE + 32'h14, 1'b1, 32'h0100, 4'b0010, g, l, r, aa);
    checks++; if (irq !== 3'b000) begin errors++; $display("FAIL final_w1c got %b exp 000", irq); end
    io_in[8] = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [5:0] pat;
    bit dat_bad;
    pat = '0; dat_bad = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h04; sel = 4'hF;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      pat[k] = ack;
      if (ack ? (dat_o !== 32'h0000_FFFF) : (dat_o !== 32'h0)) dat_bad = 1'b1;
    end
    cyc = 1'b0; stb = 1'b0;
    checks++; if (pat !== 6'b010101) begin errors++; $display("FAIL b2b_ack got %b exp 010101", pat); end
    checks++; if (dat_bad !== 1'b0) begin errors++; $display("FAIL b2b_dat got %b exp 0", dat_bad); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit seen;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h04; sel = 4'hF;
    @(posedge clk); #1;
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rmid_pre_ack got %b exp 1", ack); end
    rst_n = 1'b0; #1;
    checks++; if (ack !== 1'b0 || dat_o !== 32'h0) begin errors++; $display("FAIL rmid_drop got %b/%h exp 0/0", ack, dat_o); end
    cyc = 1'b0; stb = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (ack) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rmid_noack got %b exp 0", seen); end
    checks++; if (io_oeb !== 16'hFFFF || io_out !== 16'h0 || irq !== 3'b000) begin errors++; $display("FAIL rmid_state got %h/%h/%b exp ffff/0000/000", io_oeb, io_out, irq); end
  endtask

  initial begin
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; wdat = '0;
    io_in = '0; la_in = '0; la_oenb = '1;
    test_reset();
    test_write_lanes();
    test_unmapped();
    test_la_override();
    test_err();
    test_irq();
    test_set_wins();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
